// File: rtl/alu_responder.sv
// alu_responder: registered valid/ready wrapper around the 4-bit ALU command set.
// Commands are computed at acceptance, queued in a small FIFO and returned in
// acceptance order on the response channel. Outputs are driven from the FIFO head.
module alu_responder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             A0,
  input  logic             A1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   result,
  output logic [WIDTH-1:0] answer,
  output logic             eq,
  output logic             less,
  output logic             great,
  output logic [1:0]       rsp_op,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_SUB = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH:0]   result;
    logic [WIDTH-1:0] answer;
    logic             eq;
    logic             less;
    logic             great;
  } rsp_t;

  rsp_t          mem [DEPTH];
  rsp_t          cmd;
  rsp_t          head;
  op_e           cmd_op;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] hidx;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign cmd_op    = op_e'({A1, A0});
  assign rsp_valid = (count != '0);
  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // When empty, show the slot just behind the read pointer: it holds the last
  // popped response and is the last slot a push would overwrite.
  assign hidx = rsp_valid ? rd_ptr : (rd_ptr - 1'b1);
  assign head = mem[hidx];

  assign result = head.result;
  assign answer = head.answer;
  assign eq     = head.eq;
  assign less   = head.less;
  assign great  = head.great;
  assign rsp_op = head.op;

  // Decode and compute the response for the command on the request inputs.
  always_comb begin
    cmd    = '0;
    cmd.op = {A1, A0};
    unique case (cmd_op)
      OP_ADD: cmd.result = {1'b0, A} + {1'b0, B};
      OP_CMP: begin
        cmd.eq    = (A == B);
        cmd.less  = (A < B);
        cmd.great = (A > B);
      end
      OP_SUB: cmd.result = {1'b0, A} - {1'b0, B};
      OP_AND: cmd.answer = A & B;
    endcase
  end

  // FIFO storage, pointers, occupancy and completed-transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '{default: '0};
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      txn_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        txn_count <= txn_count + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: directed and randomised checks of alu_responder.
module tb_alu_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       A0;
  logic       A1;
  logic [3:0] A;
  logic [3:0] B;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] result;
  logic [3:0] answer;
  logic       eq;
  logic       less;
  logic       great;
  logic [1:0] rsp_op;
  logic [7:0] txn_count;

  int nvec = 0;
  int nerr = 0;

  alu_responder #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .A0        (A0),
    .A1        (A1),
    .A         (A),
    .B         (B),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .answer    (answer),
    .eq        (eq),
    .less      (less),
    .great     (great),
    .rsp_op    (rsp_op),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic rr);
    req_valid = v;
    {A1, A0}  = op;
    A         = a;
    B         = b;
    rsp_ready = rr;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_result"},    {27'd0, result},    32'd0);
    chk({tag, "_answer"},    {28'd0, answer},    32'd0);
    chk({tag, "_flags"},     {29'd0, eq, less, great}, 32'd0);
    chk({tag, "_rsp_op"},    {30'd0, rsp_op},    32'd0);
    chk({tag, "_txn"},       {24'd0, txn_count}, 32'd0);
  endtask

  // Expected response packed as {op, result, answer, eq, less, great}.
  function automatic logic [13:0] model(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] r;
    logic [3:0] n;
    logic [2:0] f;
    r = '0;
    n = '0;
    f = '0;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   f = {a == b, a < b, a > b};
      2'b10:   r = {1'b0, a} - {1'b0, b};
      default: n = a & b;
    endcase
    return {op, r, n, f};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  t3_op [3];
    logic [3:0]  t3_a  [3];
    logic [3:0]  t3_b  [3];
    logic [4:0]  t3_r  [3];
    logic [13:0] q [$];
    logic [13:0] exp_rsp;
    logic        v;
    logic        rr;
    logic [1:0]  opr;
    logic [3:0]  ar;
    logic [3:0]  br;
    int          acc;
    int          pops;
    int          cyc;

    t3_op = '{2'b00, 2'b10, 2'b10};
    t3_a  = '{4'hE, 4'hC, 4'h3};
    t3_b  = '{4'h3, 4'h3, 4'hC};
    t3_r  = '{5'b10001, 5'b01001, 5'b10111};

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    #2;
    reset_chk("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AND, single response
    @(negedge clk);
    drive(1'b1, 2'b11, 4'hE, 4'h3, 1'b1);
    chk("t1_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_answer", {28'd0, answer}, 32'h2);
    chk("t1_result", {27'd0, result}, 32'h0);
    chk("t1_flags", {29'd0, eq, less, great}, 32'd0);
    chk("t1_rsp_op", {30'd0, rsp_op}, 32'd3);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("t1_empty", {31'd0, rsp_valid}, 32'd0);
    chk("t1_txn", {24'd0, txn_count}, 32'd1);

    // Back-to-back compares
    drive(1'b1, 2'b01, 4'hA, 4'h5, 1'b1);
    @(negedge clk);
    chk("t2_req_ready0", {31'd0, req_ready}, 32'd1);
    chk("t2_valid0", {31'd0, rsp_valid}, 32'd1);
    chk("t2_flags0", {29'd0, eq, less, great}, 32'b001);
    drive(1'b1, 2'b01, 4'hA, 4'hA, 1'b1);
    @(negedge clk);
    chk("t2_req_ready1", {31'd0, req_ready}, 32'd1);
    chk("t2_valid1", {31'd0, rsp_valid}, 32'd1);
    chk("t2_flags1", {29'd0, eq, less, great}, 32'b100);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("t2_empty", {31'd0, rsp_valid}, 32'd0);
    chk("t2_txn", {24'd0, txn_count}, 32'd3);

    // Arithmetic vectors
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t3_op[i], t3_a[i], t3_b[i], 1'b1);
      @(negedge clk);
      chk($sformatf("t3_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("t3_result%0d", i), {27'd0, result}, {27'd0, t3_r[i]});
      chk($sformatf("t3_flags%0d", i), {29'd0, eq, less, great}, 32'd0);
      drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
      @(negedge clk);
    end
    chk("t3_txn", {24'd0, txn_count}, 32'd6);

    // Backpressure: fill, hold third command, then drain
    drive(1'b1, 2'b00, 4'h1, 4'h1, 1'b0);
    @(negedge clk);
    chk("t4_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t4_head0", {27'd0, result}, 32'd2);
    chk("t4_ready0", {31'd0, req_ready}, 32'd1);
    drive(1'b1, 2'b00, 4'h2, 4'h2, 1'b0);
    @(negedge clk);
    chk("t4_full", {31'd0, req_ready}, 32'd0);
    chk("t4_head1", {27'd0, result}, 32'd2);
    drive(1'b1, 2'b00, 4'h3, 4'h3, 1'b0);
    @(negedge clk);
    chk("t4_held", {31'd0, req_ready}, 32'd0);
    chk("t4_stable", {27'd0, result}, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready1", {31'd0, req_ready}, 32'd1);
    chk("t4_second", {27'd0, result}, 32'd4);
    @(negedge clk);
    chk("t4_third", {27'd0, result}, 32'd6);
    chk("t4_valid3", {31'd0, rsp_valid}, 32'd1);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("t4_empty", {31'd0, rsp_valid}, 32'd0);
    chk("t4_txn", {24'd0, txn_count}, 32'd9);
    chk("t4_hold_last", {27'd0, result}, 32'd6);

    // Randomised stress against the model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc  = 0;
    pops = 0;
    cyc  = 0;
    while ((acc < 300 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      v   = (acc < 300) && ($urandom_range(0, 3) != 0);
      opr = 2'($urandom_range(0, 3));
      ar  = 4'($urandom_range(0, 15));
      br  = 4'($urandom_range(0, 15));
      rr  = 1'($urandom_range(0, 1));
      drive(v, opr, ar, br, rr);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("stress_extra", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_rsp = q.pop_front();
          chk($sformatf("stress_rsp%0d", pops), {18'd0, rsp_op, result, answer, eq, less, great},
              {18'd0, exp_rsp});
          pops++;
        end
      end
      if (req_valid && req_ready) begin
        q.push_back(model(opr, ar, br));
        acc++;
      end
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    chk("stress_pops", pops, 32'd300);
    chk("stress_empty", {31'd0, rsp_valid}, 32'd0);
    chk("stress_txn", {24'd0, txn_count}, 32'd44);

    // Asynchronous reset with the FIFO full
    drive(1'b1, 2'b00, 4'h1, 4'h2, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b00, 4'h3, 4'h4, 1'b0);
    @(negedge clk);
    chk("t6_full", {31'd0, req_ready}, 32'd0);
    chk("t6_head", {27'd0, result}, 32'd3);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_chk("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 4'h5, 4'h7, 1'b1);
    @(negedge clk);
    chk("t6_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t6_result", {27'd0, result}, 32'h1E);
    chk("t6_rsp_op", {30'd0, rsp_op}, 32'd2);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    chk("t6_empty", {31'd0, rsp_valid}, 32'd0);
    chk("t6_txn", {24'd0, txn_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
